// File: rtl/rv32_pkg.sv
// Shared RV32I encoding constants: format codes, opcodes, immediate limits
// and the FIFO entry layout used by the instruction encoder.
package rv32_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRX = 3'b101;

  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMM13_MIN = -4096;
  localparam int IMM13_MAX = 4094;
  localparam int IMM21_MIN = -1048576;
  localparam int IMM21_MAX = 1048574;
  localparam int SHAMT_MAX = 31;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
  } enc_word_t;

  // Treats the raw 32-bit immediate as two's complement.
  function automatic logic in_range(logic [31:0] v, int lo, int hi);
    int s;
    s = int'(v);
    return (s >= lo) && (s <= hi);
  endfunction

endpackage

// File: rtl/enc_fifo2.sv
// Two-entry FIFO holding encoded words with their byte addresses.
module enc_fifo2
  import rv32_pkg::*;
#(
  parameter logic [63:0] RST_WORD = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        push,
  input  logic [63:0] din,
  input  logic        pop,
  output logic [63:0] dout,
  output logic        full,
  output logic        empty
);

  logic [63:0] mem_q [2];
  logic        wptr_q, rptr_q;
  logic [1:0]  cnt_q, cnt_d;
  logic        do_push, do_pop;

  assign full    = (cnt_q == 2'd2);
  assign empty   = (cnt_q == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rptr_q];

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop)      cnt_d = cnt_q + 2'd1;
    else if (do_pop && !do_push) cnt_d = cnt_q - 2'd1;
  end

  // Storage resets too so the idle head reads as a zero word at the base address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q[0] <= RST_WORD;
      mem_q[1] <= RST_WORD;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (clr) begin
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (do_push) mem_q[wptr_q] <= din;
      wptr_q <= wptr_q ^ do_push;
      rptr_q <= rptr_q ^ do_pop;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/inst_encoder.sv
// RV32I field-set encoder: checks immediates, packs the instruction word and
// queues it with its byte address for the instruction-memory writer.
module inst_encoder
  import rv32_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_addr,
  output logic        err,
  output logic [7:0]  err_cnt
);

  logic        rdy_q;
  logic        err_q, err_d;
  logic [7:0]  errcnt_q, errcnt_d;
  logic [31:0] waddr_q, waddr_d;
  logic [31:0] enc_inst;
  logic        legal, is_shift, accept, push, pop, full, empty;
  enc_word_t   wr_word, rd_word;

  assign is_shift = (in_fmt == FMT_I) && (in_opcode == OP_IMM) &&
                    ((in_funct3 == F3_SLL) || (in_funct3 == F3_SRX));

  always_comb begin
    enc_inst = 32'h0;
    legal    = 1'b0;
    case (in_fmt)
      FMT_R: begin
        enc_inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        legal    = 1'b1;
      end
      FMT_I: begin
        if (is_shift) begin
          enc_inst = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
          legal    = in_range(in_imm, 0, SHAMT_MAX);
        end else begin
          enc_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
          legal    = in_range(in_imm, IMM12_MIN, IMM12_MAX);
        end
      end
      FMT_S: begin
        enc_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        legal    = in_range(in_imm, IMM12_MIN, IMM12_MAX);
      end
      FMT_B: begin
        enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], in_opcode};
        legal    = in_range(in_imm, IMM13_MIN, IMM13_MAX) && !in_imm[0];
      end
      FMT_U: begin
        enc_inst = {in_imm[31:12], in_rd, in_opcode};
        legal    = (in_imm[11:0] == 12'h0);
      end
      FMT_J: begin
        enc_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        legal    = in_range(in_imm, IMM21_MIN, IMM21_MAX) && !in_imm[0];
      end
      default: legal = 1'b0;
    endcase
  end

  // rdy_q holds in_ready low through reset and raises it on the first edge after.
  assign in_ready = rdy_q && !full && !clr;
  assign accept   = in_valid && in_ready;
  assign push     = accept && legal;
  assign pop      = out_valid && out_ready && !clr;

  always_comb begin
    waddr_d  = waddr_q;
    err_d    = err_q;
    errcnt_d = errcnt_q;
    if (clr) begin
      waddr_d  = BASE_ADDR;
      err_d    = 1'b0;
      errcnt_d = 8'h0;
    end else if (push) begin
      waddr_d = waddr_q + 32'd4;
    end else if (accept) begin
      err_d = 1'b1;
      if (errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_q    <= 1'b0;
      err_q    <= 1'b0;
      errcnt_q <= 8'h0;
      waddr_q  <= BASE_ADDR;
    end else begin
      rdy_q    <= 1'b1;
      err_q    <= err_d;
      errcnt_q <= errcnt_d;
      waddr_q  <= waddr_d;
    end
  end

  assign wr_word = '{inst: enc_inst, addr: waddr_q};

  enc_fifo2 #(.RST_WORD({32'h0, BASE_ADDR})) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (push),
    .din   (wr_word),
    .pop   (pop),
    .dout  (rd_word),
    .full  (full),
    .empty (empty)
  );

  assign out_valid = !empty;
  assign out_inst  = rd_word.inst;
  assign out_addr  = rd_word.addr;
  assign err       = err_q;
  assign err_cnt   = errcnt_q;

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, the byte address given to the first encoded word after reset or clear.
REQ-002 SHALL have port clk, input, 1 bit: the system clock.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port clr, input, 1 bit: synchronous clear of the buffer, address counter and error state.
REQ-005 SHALL have port in_valid, input, 1 bit: the field set is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the encoder can accept a field set.
REQ-007 SHALL have port in_fmt, input, 3 bits: format select, 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
REQ-008 SHALL have ports in_opcode (input, 7 bits), in_funct3 (input, 3 bits) and in_funct7 (input, 7 bits): the instruction fields.
REQ-009 SHALL have ports in_rd, in_rs1 and in_rs2, each input, 5 bits: register indices.
REQ-010 SHALL have port in_imm, input, 32 bits: the signed immediate or byte offset; for U format it is the full upper value.
REQ-011 SHALL have port out_valid, output, 1 bit: the head word is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer (instruction-memory writer) takes the head word.
REQ-013 SHALL have port out_inst, output, 32 bits: the encoded RV32I instruction word.
REQ-014 SHALL have port out_addr, output, 32 bits: the byte address for out_inst.
REQ-015 SHALL have port err, output, 1 bit: sticky flag set by any rejected field set.
REQ-016 SHALL have port err_cnt, output, 8 bits: count of rejected field sets, saturating at 255.

Function
REQ-017 SHALL accept a field set on a rising clk edge only when in_valid=1 and in_ready=1.
REQ-018 SHALL drive in_ready = !full && !clr, with no combinational path from out_ready.
REQ-019 SHALL encode the fields combinationally and write the encoded word into a 2-entry FIFO at the accepting edge, so the word is visible on out_inst one cycle after acceptance.
REQ-020 SHALL place fields as follows:
- R: funct7|rs2|rs1|funct3|rd|opcode.
- I: imm[11:0]|rs1|funct3|rd|opcode.
- S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
- B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
- U: imm[31:12]|rd|opcode.
- J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
REQ-021 SHALL treat an I-format shift (opcode 0010011 with funct3 001 or 101) as follows: bits [31:25] are funct7, bits [24:20] are imm[4:0], and imm must lie in 0..31.
REQ-022 SHALL reject a field set whose immediate is out of range:
- I and S: outside -2048..2047.
- B: outside -4096..4094, or odd.
- J: outside -1048576..1048574, or odd.
- U: imm[11:0] != 0.
REQ-023 SHALL reject any in_fmt of 6 or 7.
REQ-024 SHALL, on a rejected but accepted field set, push nothing, leave the address unchanged, set err and increment err_cnt, saturating at 255.
REQ-025 SHALL store with each FIFO entry the current write address, then advance the write address by 4, wrapping modulo 2^32.
REQ-026 SHALL drive out_valid=1 when the FIFO is not empty, with out_inst and out_addr taken from the head entry and held stable while out_valid=1 and out_ready=0.
REQ-027 SHALL pop the head entry when out_valid=1 and out_ready=1.
REQ-028 SHALL allow a push and a pop in the same cycle when the FIFO is not full; occupancy is then unchanged.
REQ-029 SHALL, on clr=1 at a clock edge, empty the FIFO, set the write address to BASE_ADDR, clear err and err_cnt, and accept no input; clr takes priority over any simultaneous push or pop.

Reset
REQ-030 SHALL, while rst=0, asynchronously force in_ready=0, out_valid=0, out_inst=0, out_addr=BASE_ADDR, err=0, err_cnt=0, the FIFO to empty, and the write address to BASE_ADDR.
REQ-031 SHALL discard all buffered words when reset occurs mid-operation.
REQ-032 SHALL assert in_ready=1 on the first edge after rst is released.

Structure
REQ-033 SHALL place the format codes (FMT_R..FMT_J), the RV32I opcode constants and the immediate range limits in a shared package, rv32_pkg.
REQ-034 SHALL implement the FIFO as the sub-module enc_fifo2: 2 entries of 64 bits each (instruction and address), with push, pop, full and empty.

Verification
REQ-035 SHALL check that I, opcode 0010011, rd=1, rs1=0, funct3=0, imm=5 after reset produces out_inst=0x00500093 and out_addr=0x00000000.
REQ-036 SHALL check that S, opcode 0100011, funct3=010, rs1=31, rs2=2, imm=8 as the second word produces out_inst=0x002FA423 and out_addr=0x00000004.
REQ-037 SHALL check that B, opcode 1100011, funct3=0, rs1=1, rs2=2, imm=-4 produces out_inst=0xFE208EE3.
REQ-038 SHALL check that I with imm=2048 causes no push, err=1, err_cnt=1, and the next legal word still receives the un-advanced address.
REQ-039 SHALL check that with out_ready=0 and 3 back-to-back valid sets, in_ready drops after 2 acceptances; after out_ready=1 the words drain in order with addresses +0, +4 and +8.
REQ-040 SHALL check that with 2 words buffered, pulsing rst=0 gives out_valid=0 immediately, and the next word gets out_addr=BASE_ADDR.
